// File: rtl/program_loader.sv
// Byte-stream program loader: parses SYNC/ADDR/LEN/DATA/CHK frames, writes DATA into memory
// and keeps the CPU in reset until a frame with a good checksum has been loaded.
module program_loader #(
  parameter int unsigned              ADDR_WIDTH = 16,
  parameter int unsigned              DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]    SYNC_BYTE  = 8'hA5,
  parameter bit                       CHECK_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  mem_busy,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [DATA_WIDTH-1:0] chk;
  logic                  accept;

  // Back-pressure follows the memory port directly so no byte is taken that cannot be written.
  assign rx_ready = reset && !mem_busy;
  assign accept   = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      chk        <= '0;
      remaining  <= '0;
      addr       <= '0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        unique case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (rx_data == SYNC_BYTE) begin
              state      <= S_ADDR_HI;
              cpu_hold   <= 1'b1;
              load_done  <= 1'b0;
              load_error <= 1'b0;
              chk        <= '0;
            end
          end
          S_ADDR_HI: begin
            addr[ADDR_WIDTH-1 -: DATA_WIDTH] <= rx_data;
            state <= S_ADDR_LO;
          end
          S_ADDR_LO: begin
            addr[DATA_WIDTH-1:0] <= rx_data;
            state <= S_LEN_HI;
          end
          S_LEN_HI: begin
            remaining[ADDR_WIDTH-1 -: DATA_WIDTH] <= rx_data;
            state <= S_LEN_LO;
          end
          S_LEN_LO: begin
            remaining[DATA_WIDTH-1:0] <= rx_data;
            state <= (remaining[ADDR_WIDTH-1 -: DATA_WIDTH] == '0 && rx_data == '0) ? S_CHECK : S_DATA;
          end
          S_DATA: begin
            // Address wraps naturally at the top of the space.
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= rx_data;
            chk       <= chk ^ rx_data;
            addr      <= addr + ADDR_WIDTH'(1);
            remaining <= remaining - ADDR_WIDTH'(1);
            if (remaining == ADDR_WIDTH'(1)) state <= S_CHECK;
          end
          S_CHECK: begin
            if (!CHECK_EN || rx_data == chk) begin
              state     <= S_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state      <= S_ERROR;
              load_error <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frame-level reference model compared every cycle,
// directed frames with literal expectations, then randomized frames with back-pressure.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_busy = 1'b0;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  always #5 clk = ~clk;

  program_loader dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_busy  (mem_busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_error(load_error)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Busy generator: a forced window plus optional random busy cycles.
  int cyc = 0;
  int busy_start = -100;
  bit rand_busy = 1'b0;
  always @(posedge clk) begin
    cyc++;
    #1;
    mem_busy = (cyc >= busy_start && cyc < busy_start + 3) || (rand_busy && $urandom_range(0, 3) == 0);
  end

  // Reference model: collects bytes after SYNC and interprets them by position in the frame.
  logic [7:0]  frame[$];
  bit          in_frame = 1'b0;
  bit          model_valid = 1'b0;
  bit          m_hold = 1'b1, m_done = 1'b0, m_err = 1'b0, m_we = 1'b0;
  logic [15:0] m_addr = 16'h0;
  logic [7:0]  m_wdata = 8'h0;
  int          m_n, m_len;
  logic [7:0]  m_x;

  always @(posedge clk) begin
    m_we = 1'b0;
    if (!reset) begin
      in_frame = 1'b0;
      frame.delete();
      m_hold = 1'b1; m_done = 1'b0; m_err = 1'b0;
      model_valid = 1'b1;
    end else if (rx_valid && !mem_busy) begin
      if (!in_frame) begin
        if (rx_data == 8'hA5) begin
          in_frame = 1'b1;
          frame.delete();
          m_hold = 1'b1; m_done = 1'b0; m_err = 1'b0;
        end
      end else begin
        frame.push_back(rx_data);
        m_n = frame.size();
        if (m_n > 4) begin
          m_len = int'({frame[2], frame[3]});
          if (m_n <= 4 + m_len) begin
            m_we    = 1'b1;
            m_addr  = 16'(int'({frame[0], frame[1]}) + m_n - 5);
            m_wdata = rx_data;
          end else begin
            m_x = 8'h00;
            for (int i = 4; i < 4 + m_len; i++) m_x ^= frame[i];
            m_done   = (m_x == rx_data);
            m_err    = !m_done;
            m_hold   = !m_done;
            in_frame = 1'b0;
          end
        end
      end
    end
  end

  // Literal-check requests from the stimulus process, served by the compare process.
  int tmo_cnt = 0;
  int lit_id = 0, lit_seq = 0, lit_seen = 0;
  int wr_base = 0, lit_n = 0;
  int wr_count = 0;
  logic [7:0] tb_mem [0:65535];

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      tb_mem[mem_addr] = mem_wdata;
      wr_count++;
    end
    if (model_valid) begin
      check("mem_we", 32'(mem_we), 32'(m_we));
      if (m_we) begin
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      end
      check("cpu_hold", 32'(cpu_hold), 32'(m_hold));
      check("load_done", 32'(load_done), 32'(m_done));
      check("load_error", 32'(load_error), 32'(m_err));
      check("flags_exclusive", 32'(load_done && load_error), 32'd0);
    end
    check("rx_ready", 32'(rx_ready), 32'(reset && !mem_busy));
    check("timeout", 32'(tmo_cnt), 32'd0);
    if (lit_seq != lit_seen) begin
      case (lit_id)
        0: begin
          check("rst_mem_we", 32'(mem_we), 32'd0);
          check("rst_mem_addr", 32'(mem_addr), 32'd0);
          check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
          check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
          check("rst_load_done", 32'(load_done), 32'd0);
          check("rst_load_error", 32'(load_error), 32'd0);
          check("rst_rx_ready", 32'(rx_ready), 32'd0);
        end
        1: begin
          check("t1_mem_f000", 32'(tb_mem[16'hF000]), 32'h3E);
          check("t1_mem_f001", 32'(tb_mem[16'hF001]), 32'hFF);
          check("t1_mem_f002", 32'(tb_mem[16'hF002]), 32'hC3);
          check("t1_done", 32'(load_done), 32'd1);
          check("t1_hold", 32'(cpu_hold), 32'd0);
          check("t1_err", 32'(load_error), 32'd0);
          check("t1_model_done", 32'(m_done), 32'd1);
        end
        2: begin
          check("t2_err", 32'(load_error), 32'd1);
          check("t2_hold", 32'(cpu_hold), 32'd1);
          check("t2_done", 32'(load_done), 32'd0);
          check("t2_model_err", 32'(m_err), 32'd1);
        end
        3: begin
          check("t3_mem_ffff", 32'(tb_mem[16'hFFFF]), 32'h11);
          check("t3_mem_0000", 32'(tb_mem[16'h0000]), 32'h22);
          check("t3_done", 32'(load_done), 32'd1);
        end
        4: check("t4_done", 32'(load_done), 32'd1);
        5: begin
          for (int i = 0; i < 5; i++)
            check("t5_mem", 32'(tb_mem[16'h4000 + 16'(i)]), 32'h60 + 32'(i));
          check("t5_done", 32'(load_done), 32'd1);
        end
        6: begin
          check("t6_hold", 32'(cpu_hold), 32'd1);
          check("t6_done", 32'(load_done), 32'd0);
          check("t6_err", 32'(load_error), 32'd0);
        end
        7: begin
          check("t7_mem_2000", 32'(tb_mem[16'h2000]), 32'hAA);
          check("t7_mem_2001", 32'(tb_mem[16'h2001]), 32'h55);
          check("t7_done", 32'(load_done), 32'd1);
        end
        default: ;
      endcase
      check("write_count", 32'(wr_count - wr_base), 32'(lit_n));
      lit_seen = lit_seq;
    end
  end

  bit gaps = 1'b0;

  task automatic lit(input int id, input int n);
    lit_id = id;
    lit_n  = n;
    lit_seq++;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  guard;
    bit  taken;
    guard = 0;
    taken = 1'b0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!taken) begin
      @(posedge clk);
      taken = !mem_busy && reset;
      #1;
      guard++;
      if (guard > 200) begin
        tmo_cnt++;
        taken = 1'b1;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] a, input logic [15:0] len);
    send_byte(8'hA5);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [7:0] d[$], input logic [7:0] c);
    send_hdr(a, 16'(d.size()));
    foreach (d[i]) send_byte(d[i]);
    send_byte(c);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] dq[$];
  logic [7:0] x;
  logic [15:0] ra;
  int rl;

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    wr_base = wr_count;
    lit(0, 0);
    reset = 1'b1;
    idle(2);

    // 1: good frame
    wr_base = wr_count;
    dq = '{8'h3E, 8'hFF, 8'hC3};
    send_frame(16'hF000, dq, 8'h02);
    idle(3);
    lit(1, 3);

    // 2: bad checksum, writes still happen
    wr_base = wr_count;
    send_frame(16'hF000, dq, 8'h00);
    idle(3);
    lit(2, 3);

    // 3: address wrap
    wr_base = wr_count;
    dq = '{8'h11, 8'h22};
    send_frame(16'hFFFF, dq, 8'h33);
    idle(3);
    lit(3, 2);

    // 4: noise then zero-length frame
    wr_base = wr_count;
    send_byte(8'h00);
    send_byte(8'h7E);
    dq.delete();
    send_frame(16'h0010, dq, 8'h00);
    idle(3);
    lit(4, 0);

    // 5: memory busy for three cycles mid-DATA
    wr_base = wr_count;
    send_hdr(16'h4000, 16'd5);
    send_byte(8'h60);
    busy_start = cyc + 1;
    send_byte(8'h61);
    send_byte(8'h62);
    send_byte(8'h63);
    send_byte(8'h64);
    send_byte(8'h60 ^ 8'h61 ^ 8'h62 ^ 8'h63 ^ 8'h64);
    idle(3);
    lit(5, 5);

    // 6: reset after two of three data bytes, then reload
    wr_base = wr_count;
    send_hdr(16'h3000, 16'd3);
    send_byte(8'h01);
    send_byte(8'h02);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(3);
    lit(6, 2);
    wr_base = wr_count;
    dq = '{8'hAA, 8'h55};
    send_frame(16'h2000, dq, 8'hFF);
    idle(3);
    lit(7, 2);

    // Randomized frames with noise, gaps, back-pressure and occasional bad checksums.
    rand_busy = 1'b1;
    gaps = 1'b1;
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        x = 8'($urandom_range(0, 255));
        if (x == 8'hA5) x = 8'h00;
        send_byte(x);
      end
      ra = 16'($urandom_range(0, 65535));
      rl = int'($urandom_range(0, 8));
      dq.delete();
      x = 8'h00;
      for (int k = 0; k < rl; k++) begin
        dq.push_back(8'($urandom_range(0, 255)));
        x ^= dq[k];
      end
      if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
      send_frame(ra, dq, x);
      idle(int'($urandom_range(0, 3)));
    end
    rand_busy = 1'b0;
    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
